pes_sdw_ser: RTL and testbench

//   Parallel-to-serial front end for the 1010 sequence-detector stage.
//   - Accepts WIDTH-bit words over a valid/ready handshake.
//   - Shifts each word out one bit per clock on dout, which drives the detector's serial din input.
//   - A one-word holding register lets back-to-back words stream with no idle gap.
//   - Between words, dout carries IDLE_BIT with dout_valid low.

---
 rtl/pes_sdw_ser.sv | 127 ++++++++++++
 tb/tb_pes_sdw_ser.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pes_sdw_ser.sv
// Parallel-to-serial front end for the 1010 sequence detector: WIDTH-bit words in over
// valid/ready, one bit per clock out on o_dout, with a one-word holding register for gap-free streaming.
module pes_sdw_ser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_dout,
    output logic             o_dout_valid,
    output logic             o_word_done,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic [WIDTH-1:0] r_hold, w_hold_next;
    logic             r_hold_full, w_hold_full_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_dout, w_dout_next;
    logic             r_dout_valid, w_dout_valid_next;
    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_load_word;

    // Bit that goes out first from a word, and what remains once it has gone.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign o_ready  = i_rst_n & ~r_hold_full;
    assign w_accept = i_valid & o_ready;
    assign w_last   = r_dout_valid & (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_cnt        <= '0;
            r_dout       <= IDLE_BIT;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_hold       <= w_hold_next;
            r_hold_full  <= w_hold_full_next;
            r_cnt        <= w_cnt_next;
            r_dout       <= w_dout_next;
            r_dout_valid <= w_dout_valid_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_hold_next       = r_hold;
        w_hold_full_next  = r_hold_full;
        w_cnt_next        = r_cnt;
        w_dout_next       = r_dout;
        w_dout_valid_next = r_dout_valid;
        w_load            = 1'b0;
        w_load_word       = i_data;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    // Holding register has priority; it can only be full when o_ready is low.
                    if (r_hold_full) begin
                        w_load           = 1'b1;
                        w_load_word      = r_hold;
                        w_hold_full_next = 1'b0;
                    end else if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next      = ST_IDLE;
                        w_dout_next       = IDLE_BIT;
                        w_dout_valid_next = 1'b0;
                        w_cnt_next        = '0;
                    end
                end else begin
                    w_dout_next  = head(r_shift);
                    w_shift_next = tail(r_shift);
                    w_cnt_next   = r_cnt + CW'(1);
                    if (w_accept) begin
                        w_hold_next      = i_data;
                        w_hold_full_next = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_load) begin
            w_state_next      = ST_SHIFT;
            w_dout_next       = head(w_load_word);
            w_shift_next      = tail(w_load_word);
            w_cnt_next        = '0;
            w_dout_valid_next = 1'b1;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_word_done  = r_dout_valid & (r_cnt == LAST);
    assign o_busy       = (r_state == ST_SHIFT) | r_hold_full;

endmodule

// File: tb/tb_pes_sdw_ser.sv
// Self-checking bench for pes_sdw_ser: a two-deep word FIFO model predicts the bit stream,
// handshake and status outputs every cycle; a second instance covers LSB-first order.
module tb_pes_sdw_ser;
    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data  = '0;
    logic         valid = 1'b0;
    logic         ready, dout, dv, done, busy;

    logic [W-1:0] l_data  = '0;
    logic         l_valid = 1'b0;
    logic         l_ready, l_dout, l_dv, l_done, l_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: words accepted but not yet started, and bits of the word now on the wire.
    logic [W-1:0] wq[$];
    logic         bq[$];
    bit           last_acc;

    always #5 clk = ~clk;

    pes_sdw_ser #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
        .o_ready(ready), .o_dout(dout), .o_dout_valid(dv), .o_word_done(done), .o_busy(busy)
    );

    pes_sdw_ser #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(l_data), .i_valid(l_valid),
        .o_ready(l_ready), .o_dout(l_dout), .o_dout_valid(l_dv), .o_word_done(l_done), .o_busy(l_busy)
    );

    function automatic logic [4:0] obs_vec();
        return {ready, busy, dv, done, dout};
    endfunction

    function automatic logic [4:0] exp_vec();
        logic r, b, v, d, o;
        r = rst_n && (wq.size() == 0);
        b = (bq.size() > 0) || (wq.size() > 0);
        v = bq.size() > 0;
        d = bq.size() == 1;
        o = (bq.size() > 0) ? bq[0] : 1'b0;
        return {r, b, v, d, o};
    endfunction

    // One clock: advance the model with what the bench drove, land on the next falling edge.
    task automatic tick();
        bit acc;
        logic [W-1:0] w;
        acc = valid && rst_n && (wq.size() == 0);
        @(posedge clk);
        last_acc = acc;
        if (!rst_n) begin
            wq.delete();
            bq.delete();
        end else begin
            if (bq.size() > 0) void'(bq.pop_front());
            if (acc) wq.push_back(data);
            if (bq.size() == 0 && wq.size() > 0) begin
                w = wq.pop_front();
                for (int k = 0; k < W; k++) bq.push_back(w[W-1-k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b (ready,busy,valid,done,dout)", obs_vec(), 5'b0);
        end
        n_cmp++;
        if ({l_ready, l_busy, l_dv, l_done, l_dout} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state_lsb: got %b want %b", {l_ready, l_busy, l_dv, l_done, l_dout}, 5'b0);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs_vec(), exp_vec());
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [W-1:0] got;
        int ndone;
        got = '0;
        ndone = 0;
        data = 8'hA5;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_a5 cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (dv) got = {got[W-2:0], dout};
            if (done) ndone++;
            tick();
        end
        n_cmp++;
        if (got !== 8'hA5 || ndone != 1) begin
            n_fail++;
            $display("FAIL single_a5_stream: got %h/%0d done want a5/1", got, ndone);
        end
        $display("test_single: stream %h, word_done pulses %0d", got, ndone);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[2];
        logic [15:0] got;
        int nbits, d0, d1, cyc;
        words[0] = 8'h0A;
        words[1] = 8'hF0;
        got = '0;
        nbits = 0;
        d0 = -1;
        d1 = -1;
        cyc = 0;
        for (int j = 0; j < 2; j++) begin
            data = words[j];
            valid = 1'b1;
            last_acc = 1'b0;
            for (int t = 0; t < 30 && !last_acc; t++) begin
                tick();
                cyc++;
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL b2b cyc%0d: got %b want %b", cyc, obs_vec(), exp_vec());
                end
                if (dv) begin got = {got[14:0], dout}; nbits++; end
                if (done) begin if (d0 < 0) d0 = cyc; else d1 = cyc; end
            end
            n_cmp++;
            if (!last_acc) begin
                n_fail++;
                $display("FAIL b2b_accept_timeout: word %0d got not-accepted want accepted", j);
            end
        end
        valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            cyc++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got %b want %b", cyc, obs_vec(), exp_vec());
            end
            if (dv) begin got = {got[14:0], dout}; nbits++; end
            if (done) begin if (d0 < 0) d0 = cyc; else d1 = cyc; end
        end
        n_cmp++;
        if (got !== 16'h0AF0 || nbits != 16 || (d1 - d0) != 8) begin
            n_fail++;
            $display("FAIL b2b_stream: got %h bits=%0d done_gap=%0d want 0af0 bits=16 done_gap=8", got, nbits, d1 - d0);
        end
        $display("test_back_to_back: stream %h, done gap %0d", got, d1 - d0);
    endtask

    task automatic test_reset_mid_word();
        data = 8'($urandom);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, dv, dout, ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b want 0000 (busy,valid,dout,ready)", {busy, dv, dout, ready});
        end
        wq.delete();
        bq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %b want 1", ready);
        end
        @(negedge clk);
        data = 8'($urandom);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_restart cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        $display("test_reset_mid_word done");
    endtask

    task automatic test_hold_block();
        logic [W-1:0] words[3];
        int k, run, maxrun;
        for (int j = 0; j < 3; j++) words[j] = 8'($urandom);
        k = 0;
        run = 0;
        maxrun = 0;
        data = words[0];
        valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            // Right before the edge that retires word 1 the hold is full and must refuse word 3.
            if (dv && done && k == 2) begin
                n_cmp++;
                if (ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_block_ready: got %b want 0", ready);
                end
            end
            tick();
            if (last_acc) begin
                k++;
                if (k < 3) data = words[k]; else valid = 1'b0;
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold_block cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            run = dv ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        n_cmp++;
        if (k != 3 || maxrun != 3 * W) begin
            n_fail++;
            $display("FAIL hold_block_stream: got accepted=%0d run=%0d want accepted=3 run=%0d", k, maxrun, 3 * W);
        end
        $display("test_hold_block: words %h %h %h, longest valid run %0d", words[0], words[1], words[2], maxrun);
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] w;
        for (int n = 0; n < 4; n++) begin
            w = (n == 0) ? 8'h01 : 8'($urandom);
            l_data = w;
            l_valid = 1'b1;
            tick();
            l_valid = 1'b0;
            for (int k = 0; k < W; k++) begin
                n_cmp++;
                if ({l_dv, l_done, l_dout} !== {1'b1, (k == W - 1), w[k]}) begin
                    n_fail++;
                    $display("FAIL lsb_first word %h bit%0d: got %b want %b", w, k,
                             {l_dv, l_done, l_dout}, {1'b1, (k == W - 1), w[k]});
                end
                tick();
            end
            n_cmp++;
            if ({l_dv, l_dout, l_busy} !== 3'b0) begin
                n_fail++;
                $display("FAIL lsb_idle word %h: got %b want 000", w, {l_dv, l_dout, l_busy});
            end
            $display("test_lsb_first: word %h", w);
        end
    endtask

    task automatic test_detector();
        logic [3:0] hist;
        int since;
        logic [15:0] pulses;
        hist = '0;
        since = 4;
        pulses = '0;
        data = 8'b1010_1010;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        // Non-overlapping 1010 detector fed by dout every clock, valid or not.
        for (int i = 1; i <= 14; i++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL detector_stream cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            hist = {hist[2:0], dout};
            since++;
            if (hist == 4'b1010 && since >= 4) begin
                pulses[i] = 1'b1;
                since = 0;
            end
            tick();
        end
        n_cmp++;
        if (pulses !== 16'h0110) begin
            n_fail++;
            $display("FAIL detector_pulses: got %b want %b", pulses, 16'h0110);
        end
        $display("test_detector: pulse map %b", pulses);
    endtask

    task automatic test_random();
        for (int i = 0; i < 420; i++) begin
            valid = (i < 400) && ($urandom_range(0, 99) < 60);
            data = 8'($urandom);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        valid = 1'b0;
        $display("test_random: 420 cycles");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_word();
        test_hold_block();
        test_lsb_first();
        test_detector();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
